// File: rtl/sd_block_rx_pkg.sv
// Shared types and constants for the SD single-block SPI receiver.
package sd_block_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHunt,
    StData,
    StCrc
  } state_e;

  // Card idles the line at 0xFF and opens a data block with 0xFE.
  localparam logic [7:0] TokIdle  = 8'hFF;
  localparam logic [7:0] TokStart = 8'hFE;

  localparam int unsigned BlockLen = 512;
  localparam int unsigned CrcLen   = 2;

  localparam logic [9:0] LastDataIdx = 10'(BlockLen - 1);
  localparam logic [9:0] CrcDoneCnt  = 10'(CrcLen);

endpackage

// File: rtl/sd_block_rx_if.sv
// Byte stream from the block receiver to its consumer (valid/ready).
interface sd_block_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sd_spi_rxbyte.sv
// SPI bit engine: sd_clk divider, stall-before-bit, MSB-first shifter, byte strobe.
module sd_spi_rxbyte #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       stall,
  input  logic       sd_di,
  output logic       sd_clk,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic [7:0] held_byte,
  output logic       parked
);

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  logic       sclk_q, sclk_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       sample;

  // Divider/shifter next state; stall only freezes the low phase so a bit never starts.
  always_comb begin
    sclk_d  = sclk_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sample  = 1'b0;
    if (!run) begin
      sclk_d  = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      shift_d = '0;
    end else if (!(stall && !sclk_q)) begin
      if (div_q == DivLast) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        // Sample in the same cycle sd_clk is driven 0->1.
        if (!sclk_q) begin
          sample  = 1'b1;
          shift_d = {shift_q[6:0], sd_di};
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign sd_clk    = sclk_q;
  assign byte_done = sample && (bit_q == 3'd7);
  assign rx_byte   = shift_d;
  // After a byte completes the shifter keeps it until the next bit, which stall prevents.
  assign held_byte = shift_q;
  assign parked    = run && stall && !sclk_q;

endmodule

// File: rtl/sd_block_rx.sv
// SD SPI single-block read: token hunt, 512 data bytes to a valid/ready port, CRC discard.
module sd_block_rx
  import sd_block_rx_pkg::*;
#(
  parameter int unsigned CLKDIV   = 2,
  parameter int unsigned HUNT_MAX = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sd_clk,
  output logic          sd_do,
  input  logic          sd_di,
  sd_block_rx_if.master rx
);

  localparam int unsigned HuntW = $clog2(HUNT_MAX + 1);
  localparam logic [HuntW-1:0] HuntLast = HuntW'(HUNT_MAX - 1);

  state_e           state_q, state_d;
  logic [HuntW-1:0] hunt_q;
  logic [9:0]       cnt_q;
  logic             pend_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       run, stall, byte_done, parked;
  logic [7:0] rx_byte, held_byte;
  logic       data_byte, crc_halt, crc_end;

  assign run       = (state_q != StIdle);
  assign crc_halt  = (state_q == StCrc) && (cnt_q == CrcDoneCnt);
  assign stall     = pend_q || crc_halt;
  assign data_byte = (state_q == StData) && byte_done;
  // Finish only once the clock is parked low and the last data byte has been taken.
  assign crc_end   = crc_halt && parked && !out_valid_q;

  sd_spi_rxbyte #(
    .CLKDIV(CLKDIV)
  ) u_rxbyte (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .stall    (stall),
    .sd_di    (sd_di),
    .sd_clk   (sd_clk),
    .byte_done(byte_done),
    .rx_byte  (rx_byte),
    .held_byte(held_byte),
    .parked   (parked)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StHunt;
      StHunt: begin
        if (byte_done) begin
          if (rx_byte == TokStart) begin
            state_d = StData;
          end else if (rx_byte != TokIdle || hunt_q == HuntLast) begin
            state_d = StIdle;
          end
        end
      end
      StData: if (byte_done && cnt_q == LastDataIdx) state_d = StCrc;
      StCrc:  if (crc_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; done/err are registered into single-cycle pulses.
  always_comb begin
    busy   = (state_q != StIdle);
    done_d = (state_q == StCrc) && crc_end;
    err_d  = (state_q == StHunt) && byte_done && (rx_byte != TokStart) &&
             ((rx_byte != TokIdle) || (hunt_q == HuntLast));
  end

  // Pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Hunt and byte counters; both cleared whenever idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hunt_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hunt_q <= '0;
          cnt_q  <= '0;
        end
        StHunt: if (byte_done && rx_byte == TokIdle) hunt_q <= hunt_q + 1'b1;
        StData: if (byte_done) cnt_q <= (cnt_q == LastDataIdx) ? 10'd0 : cnt_q + 10'd1;
        StCrc:  if (byte_done) cnt_q <= cnt_q + 10'd1;
        default: ;
      endcase
    end
  end

  // Output register with a one-byte overflow held in the engine shifter (pend_q).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else if (pend_q) begin
      if (rx.out_ready) begin
        out_data_q <= held_byte;
        pend_q     <= 1'b0;
      end
    end else if (data_byte) begin
      if (!out_valid_q || rx.out_ready) begin
        out_data_q  <= rx_byte;
        out_valid_q <= 1'b1;
      end else begin
        pend_q <= 1'b1;
      end
    end else if (out_valid_q && rx.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign rx.out_data  = out_data_q;
  assign rx.out_valid = out_valid_q;
  assign done         = done_q;
  assign err          = err_q;
  assign sd_do        = 1'b1;

endmodule

// File: tb/tb_sd_block_rx.sv
// Directed bench for sd_block_rx with a byte-level SD card model.
module tb_sd_block_rx;

  localparam int unsigned CLKDIV   = 1;
  localparam int unsigned HUNT_MAX = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sd_di;
  logic busy, done, err, sd_clk, sd_do;

  sd_block_rx_if rx_if ();

  sd_block_rx #(
    .CLKDIV  (CLKDIV),
    .HUNT_MAX(HUNT_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sd_clk(sd_clk),
    .sd_do (sd_do),
    .sd_di (sd_di),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Card model: shifts card_mem out MSB first, changing sd_di on sd_clk falling edges.
  logic [7:0] card_mem [0:1023];
  logic [7:0] exp_mem  [0:511];
  int         card_len  = 0;
  int         card_gen  = 0;
  int         card_seen = 0;
  int         card_idx  = 0;
  logic [2:0] card_bit  = 3'd0;
  logic [7:0] card_byte;

  assign card_byte = (card_idx < card_len) ? card_mem[card_idx] : 8'hFF;
  assign sd_di     = card_byte[3'd7 - card_bit];

  always @(negedge sd_clk or card_gen) begin
    if (card_gen != card_seen) begin
      card_seen = card_gen;
      card_idx  = 0;
      card_bit  = 3'd0;
    end else if (card_bit == 3'd7) begin
      card_bit = 3'd0;
      card_idx++;
    end else begin
      card_bit = card_bit + 3'd1;
    end
  end

  // Monitors: only record observations; tasks do the comparisons.
  logic [7:0] got_mem [0:4095];
  int got_n = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cnt = 0;
  int stab_bad = 0, sdo_bad = 0, low_run = 0, stall_cnt = 0;
  int rise_cnt = 0, mosi_bits = 0, mosi_bytes = 0, mosi_bad = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rstn = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] mosi_sr = 8'h00;

  always @(negedge clk) begin
    if (rx_if.out_valid && rx_if.out_ready && got_n < 4096) begin
      got_mem[got_n] = rx_if.out_data;
      got_n++;
    end
    if (prev_valid && !prev_ready && prev_rstn &&
        (!rx_if.out_valid || rx_if.out_data != prev_data)) stab_bad++;
    prev_valid = rx_if.out_valid;
    prev_ready = rx_if.out_ready;
    prev_data  = rx_if.out_data;
    prev_rstn  = rst_n;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (rx_if.out_valid) valid_cnt++;
    if (sd_do !== 1'b1) sdo_bad++;
    if (busy && !sd_clk) begin
      low_run++;
      if (low_run == CLKDIV + 1) stall_cnt++;
    end else begin
      low_run = 0;
    end
  end

  always @(posedge sd_clk) begin
    rise_cnt++;
    mosi_sr = {mosi_sr[6:0], sd_do};
    mosi_bits++;
    if (mosi_bits == 8) begin
      mosi_bits = 0;
      mosi_bytes++;
      if (mosi_sr != 8'hFF) mosi_bad++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic load_block(input int n_ff, input logic [7:0] tok, input int n_data);
    int k = 0;
    for (int i = 0; i < n_ff; i++) begin
      card_mem[k] = 8'hFF;
      k++;
    end
    card_mem[k] = tok;
    k++;
    for (int i = 0; i < n_data; i++) begin
      exp_mem[i]  = 8'($urandom);
      card_mem[k] = exp_mem[i];
      k++;
    end
    if (n_data > 0) begin
      for (int i = 0; i < 2; i++) begin
        card_mem[k] = 8'($urandom);
        k++;
      end
    end
    card_len = k;
    card_gen++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (sd_clk !== 1'b0) begin errors++; $display("FAIL reset_sd_clk got %b want 0", sd_clk); end
    checks++; if (sd_do !== 1'b1) begin errors++; $display("FAIL reset_sd_do got %b want 1", sd_do); end
    checks++;
    if (rx_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", rx_if.out_valid);
    end
    checks++;
    if (rx_if.out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data got %02h want 00", rx_if.out_data);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Full block: 5x0xFF, 0xFE, 512 data, 2 CRC. mode 0: always ready, mode 1: bursty ~30% ready.
  task automatic run_block(input int mode, input string name);
    int d0 = done_cnt, e0 = err_cnt, g0 = got_n, s0 = stall_cnt;
    int n;
    bit finished = 1'b0;
    rx_if.out_ready = 1'b1;
    load_block(5, 8'hFE, 512);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_after_start got %b want 1", name, busy); end
    for (int cyc = 0; cyc < 60000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 300);
      if (mode == 0) rx_if.out_ready = 1'b1;
      else if ($urandom_range(0, 15) == 0) rx_if.out_ready = ($urandom_range(0, 9) < 3);
      if (done_cnt != d0) finished = 1'b1;
    end
    start = 1'b0;
    rx_if.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (!finished) begin errors++; $display("FAIL %s_timeout got no done want done pulse", name); end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_done_count got %0d want 1", name, done_cnt - d0);
    end
    checks++;
    if (err_cnt - e0 != 0) begin
      errors++; $display("FAIL %s_err_count got %0d want 0", name, err_cnt - e0);
    end
    n = got_n - g0;
    checks++;
    if (n != 512) begin errors++; $display("FAIL %s_byte_count got %0d want 512", name, n); end
    if (n > 512) n = 512;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_mem[g0 + i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL %s_data[%0d] got %02h want %02h", name, i, got_mem[g0 + i], exp_mem[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy got %b want 0", name, busy); end
    checks++;
    if (sd_clk !== 1'b0) begin errors++; $display("FAIL %s_idle_sd_clk got %b want 0", name, sd_clk); end
    checks++;
    if (mode == 1) begin
      if (stall_cnt - s0 == 0) begin
        errors++; $display("FAIL %s_stall_seen got 0 stalls want >0", name);
      end
    end else if (stall_cnt - s0 != 0) begin
      errors++; $display("FAIL %s_no_stall got %0d stalls want 0", name, stall_cnt - s0);
    end
  endtask

  // Shared by the two error scenarios: expect one err after exp_rises sd_clk edges.
  task automatic run_error(input int n_ff, input logic [7:0] tok, input int exp_rises,
                           input string name);
    int d0 = done_cnt, e0 = err_cnt, v0 = valid_cnt, r0 = rise_cnt;
    bit seen = 1'b0;
    rx_if.out_ready = 1'b1;
    load_block(n_ff, tok, 0);
    pulse_start();
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (err_cnt != e0) seen = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout got no err want err pulse", name); end
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++; $display("FAIL %s_err_count got %0d want 1", name, err_cnt - e0);
    end
    checks++;
    if (rise_cnt - r0 != exp_rises) begin
      errors++; $display("FAIL %s_sd_clk_rises got %0d want %0d", name, rise_cnt - r0, exp_rises);
    end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL %s_done got %0d want 0", name, done_cnt - d0); end
    checks++;
    if (valid_cnt != v0) begin
      errors++; $display("FAIL %s_out_valid got %0d cycles want 0", name, valid_cnt - v0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", name, busy); end
  endtask

  task automatic test_hunt_timeout();
    run_error(0, 8'hFF, 8 * HUNT_MAX, "hunt_timeout");
  endtask

  task automatic test_bad_token();
    run_error(2, 8'h05, 24, "bad_token");
  endtask

  task automatic test_reset_mid();
    int g0 = got_n, d0, e0, g1;
    bit reached = 1'b0;
    rx_if.out_ready = 1'b1;
    load_block(5, 8'hFE, 512);
    pulse_start();
    for (int cyc = 0; cyc < 20000 && !reached; cyc++) begin
      @(posedge clk); #1;
      if (got_n - g0 >= 100) reached = 1'b1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midrst_reach got %0d bytes want 100", got_n - g0); end
    d0 = done_cnt;
    e0 = err_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", err); end
    checks++;
    if (sd_clk !== 1'b0) begin errors++; $display("FAIL midrst_sd_clk got %b want 0", sd_clk); end
    checks++; if (sd_do !== 1'b1) begin errors++; $display("FAIL midrst_sd_do got %b want 1", sd_do); end
    checks++;
    if (rx_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_out_valid got %b want 0", rx_if.out_valid);
    end
    checks++;
    if (rx_if.out_data !== 8'h00) begin
      errors++; $display("FAIL midrst_out_data got %02h want 00", rx_if.out_data);
    end
    rst_n = 1'b1;
    g1 = got_n;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++;
      $display("FAIL midrst_pulses got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (got_n != g1) begin errors++; $display("FAIL midrst_stray_bytes got %0d want 0", got_n - g1); end
    run_block(0, "fresh_after_reset");
  endtask

  task automatic test_line_monitors();
    checks++; if (sdo_bad != 0) begin errors++; $display("FAIL sd_do_low got %0d cycles want 0", sdo_bad); end
    checks++;
    if (mosi_bad != 0) begin errors++; $display("FAIL mosi_bytes_not_ff got %0d want 0", mosi_bad); end
    checks++;
    if (mosi_bytes == 0) begin errors++; $display("FAIL mosi_bytes_seen got 0 want >0"); end
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL done_with_err got %0d want 0", both_cnt); end
    checks++;
    if (stab_bad != 0) begin errors++; $display("FAIL out_hold_stable got %0d want 0", stab_bad); end
  endtask

  initial begin
    rx_if.out_ready = 1'b1;
    test_reset();
    run_block(0, "ready_high");
    run_block(1, "ready_random");
    test_hunt_timeout();
    test_bad_token();
    test_reset_mid();
    test_line_monitors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
